// File: rtl/text_fetch_arbiter.sv
// Text-mode VRAM fetch: one display read per 32-pixel slot, CPU accesses fill the idle cycles.
// Optional CTRL_SHADOW_EN: control_out updates only at the frame boundary (tear-free).
module text_fetch_arbiter #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int VRAM_DEPTH = 600
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic        vde,
    input  logic [31:0] control_in,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [9:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        vram_en,
    output logic        vram_we,
    output logic [9:0]  vram_addr,
    output logic [31:0] vram_wdata,
    input  logic [31:0] vram_rdata,
    output logic [7:0]  code_out,
    output logic [9:0]  draw_x_out,
    output logic [9:0]  draw_y_out,
    output logic        vde_out,
    output logic [31:0] control_out
);

    localparam logic [10:0] H_LIM     = 11'(H_ACTIVE);
    localparam logic [10:0] DEPTH_LIM = 11'(VRAM_DEPTH);
`ifdef CTRL_SHADOW_EN
    localparam logic [9:0]  V_LINE    = 10'(V_ACTIVE);
`endif

    typedef enum logic [1:0] {IDLE, GRANT, DONE} cpu_state_t;

    cpu_state_t  state, state_nxt;
    logic        slot;
    logic        slot_d;
    logic [9:0]  slot_addr;
    logic        cpu_go;
    logic        in_range;
    logic        acc_rd;
    logic [31:0] word_reg;
    logic [9:0]  x_d1, y_d1;
    logic        vde_d1;

    assign slot      = vde && (draw_x[4:0] == 5'd0) && ({1'b0, draw_x} < H_LIM);
    assign slot_addr = {4'd0, draw_y[9:4]} * 10'd20 + {5'd0, draw_x[9:5]};
    assign in_range  = {1'b0, cpu_addr} < DEPTH_LIM;

    always_comb begin
        state_nxt = state;
        cpu_go    = 1'b0;
        cpu_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && !slot) begin
                    cpu_go    = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: state_nxt = DONE;
            DONE: begin
                // Gated so a reset landing in DONE never leaks an ack.
                cpu_ack   = !reset;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The CPU only touches the port in its IDLE accept cycle, so a slot
    // coinciding with GRANT/DONE owns the port without disturbing the CPU.
    always_comb begin
        vram_en    = 1'b0;
        vram_we    = 1'b0;
        vram_addr  = '0;
        vram_wdata = '0;
        if (!reset) begin
            if (slot) begin
                vram_en   = 1'b1;
                vram_addr = slot_addr;
            end else if (cpu_go && in_range) begin
                vram_en    = 1'b1;
                vram_we    = cpu_we;
                vram_addr  = cpu_addr;
                vram_wdata = cpu_wdata;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state      <= IDLE;
            acc_rd     <= 1'b0;
            cpu_rdata  <= '0;
            slot_d     <= 1'b0;
            word_reg   <= '0;
            x_d1       <= '0;
            y_d1       <= '0;
            vde_d1     <= 1'b0;
            draw_x_out <= '0;
            draw_y_out <= '0;
            vde_out    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cpu_go)
                acc_rd <= !cpu_we && in_range;
            // Writes and out-of-range reads return zero.
            if (state == GRANT)
                cpu_rdata <= acc_rd ? vram_rdata : '0;
            slot_d <= slot;
            if (slot_d)
                word_reg <= vram_rdata;
            x_d1       <= draw_x;
            y_d1       <= draw_y;
            vde_d1     <= vde;
            draw_x_out <= x_d1;
            draw_y_out <= y_d1;
            vde_out    <= vde_d1;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            control_out <= '0;
`ifdef CTRL_SHADOW_EN
        end else if (draw_x == 10'd0 && draw_y == V_LINE) begin
            control_out <= control_in;
`else
        end else begin
            control_out <= control_in;
`endif
        end
    end

    // Lowest byte of the word is the leftmost character of the 4-char group.
    assign code_out = word_reg[{draw_x_out[4:3], 3'b000} +: 8];

endmodule
